// File: rtl/uart_matrix_parser.sv
// Parses ASCII-decimal matrix text "R C e0 .. e(R*C-1)" from a UART byte stream
// and issues a single-cycle write of the assembled matrix to matrix storage.
module uart_matrix_parser #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_SIZE   = 5,
  parameter int unsigned MAX_VAL    = 9,
  parameter int unsigned MATRIX_NUM = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_done,
  output logic                     wr_en,
  output logic [2:0]               wr_idx,
  output logic [2:0]               wr_row,
  output logic [2:0]               wr_col,
  output logic [DATA_WIDTH*25-1:0] wr_data,
  output logic                     save_done,
  output logic                     parse_err,
  output logic                     busy
);

  localparam int unsigned SLOTS   = 25;
  localparam int unsigned PAY_W   = DATA_WIDTH * SLOTS;
  localparam int unsigned ACC_W   = 9;
  localparam int unsigned CALC_W  = 12;

  localparam logic [2:0] S_ROW   = 3'd0;
  localparam logic [2:0] S_COL   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]       state, state_n;
  logic [ACC_W-1:0] acc, acc_n;
  logic             tok_valid, tok_valid_n;
  logic [2:0]       row, row_n, col, col_n;
  logic [4:0]       cnt, cnt_n;
  logic [PAY_W-1:0] slots, slots_n;
  logic             wr_en_n, save_done_n, parse_err_n;
  logic [2:0]       wr_idx_n, wr_row_n, wr_col_n;
  logic [PAY_W-1:0] wr_data_n;
  logic             err;

  logic              is_digit, is_sep, is_lf;
  logic [CALC_W-1:0] acc_calc;
  logic [4:0]        total;
  logic [4:0]        cnt_inc;
  logic              size_ok;

  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_lf    = (rx_data == 8'h0A);
  assign is_sep   = (rx_data == 8'h20) || (rx_data == 8'h0D) || is_lf;
  assign acc_calc = CALC_W'(acc) * CALC_W'(10) + CALC_W'(rx_data - 8'h30);
  assign total    = 5'(row) * 5'(col);
  assign cnt_inc  = cnt + 5'd1;
  assign size_ok  = (acc >= ACC_W'(1)) && (acc <= ACC_W'(MAX_SIZE));

  assign busy = (state == S_COL) || (state == S_DATA) || (state == S_WRITE) ||
                ((state == S_ROW) && tok_valid);

  // Next-state and output decode; one byte per rx_done strobe.
  always_comb begin
    state_n     = state;
    acc_n       = acc;
    tok_valid_n = tok_valid;
    row_n       = row;
    col_n       = col;
    cnt_n       = cnt;
    slots_n     = slots;
    wr_en_n     = 1'b0;
    save_done_n = 1'b0;
    parse_err_n = 1'b0;
    wr_idx_n    = wr_idx;
    wr_row_n    = wr_row;
    wr_col_n    = wr_col;
    wr_data_n   = wr_data;
    err         = 1'b0;

    case (state)
      S_WRITE: begin
        state_n  = S_ROW;
        wr_idx_n = (wr_idx == 3'(MATRIX_NUM - 1)) ? 3'd0 : wr_idx + 3'd1;
      end
      S_ERR: begin
        if (rx_done && is_lf) state_n = S_ROW;
      end
      S_ROW, S_COL, S_DATA: begin
        if (rx_done) begin
          if (is_digit) begin
            if (acc_calc > CALC_W'(255)) begin
              err = 1'b1;
            end else begin
              acc_n       = ACC_W'(acc_calc);
              tok_valid_n = 1'b1;
            end
          end else if (is_sep) begin
            if (tok_valid) begin
              acc_n       = '0;
              tok_valid_n = 1'b0;
              if (state == S_ROW) begin
                if (size_ok) begin
                  row_n   = 3'(acc);
                  state_n = S_COL;
                end else begin
                  err = 1'b1;
                end
              end else if (state == S_COL) begin
                if (size_ok) begin
                  col_n   = 3'(acc);
                  slots_n = '0;
                  cnt_n   = '0;
                  state_n = S_DATA;
                end else begin
                  err = 1'b1;
                end
              end else begin
                if (acc <= ACC_W'(MAX_VAL)) begin
                  slots_n[int'(cnt)*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(acc);
                  cnt_n = cnt_inc;
                  if (cnt_inc == total) begin
                    state_n     = S_WRITE;
                    wr_en_n     = 1'b1;
                    save_done_n = 1'b1;
                    wr_row_n    = row;
                    wr_col_n    = col;
                    wr_data_n   = slots_n;
                  end
                end else begin
                  err = 1'b1;
                end
              end
            end
          end else begin
            err = 1'b1;
          end
        end
      end
      default: state_n = S_ROW;
    endcase

    // A rejecting LF is itself the resync point, so no extra line is skipped.
    if (err) begin
      parse_err_n = 1'b1;
      acc_n       = '0;
      tok_valid_n = 1'b0;
      state_n     = is_lf ? S_ROW : S_ERR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_ROW;
      acc       <= '0;
      tok_valid <= 1'b0;
      row       <= '0;
      col       <= '0;
      cnt       <= '0;
      slots     <= '0;
      wr_en     <= 1'b0;
      save_done <= 1'b0;
      parse_err <= 1'b0;
      wr_idx    <= '0;
      wr_row    <= '0;
      wr_col    <= '0;
      wr_data   <= '0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      tok_valid <= tok_valid_n;
      row       <= row_n;
      col       <= col_n;
      cnt       <= cnt_n;
      slots     <= slots_n;
      wr_en     <= wr_en_n;
      save_done <= save_done_n;
      parse_err <= parse_err_n;
      wr_idx    <= wr_idx_n;
      wr_row    <= wr_row_n;
      wr_col    <= wr_col_n;
      wr_data   <= wr_data_n;
    end
  end

endmodule

// File: tb/tb_uart_matrix_parser.sv
// Directed and randomized byte streams for uart_matrix_parser, checked against a
// token-level reference model of the matrix text format.
module tb_uart_matrix_parser;

  localparam int unsigned DW  = 8;
  localparam int unsigned WDW = DW * 25;

  logic           clk = 1'b0;
  logic           rst;
  logic [7:0]     rx_data;
  logic           rx_done;
  logic           wr_en;
  logic [2:0]     wr_idx;
  logic [2:0]     wr_row;
  logic [2:0]     wr_col;
  logic [WDW-1:0] wr_data;
  logic           save_done;
  logic           parse_err;
  logic           busy;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: 0=expect rows, 1=expect cols, 2=expect elements, 3=skip to LF
  int  m_mode;
  int  m_acc;
  bit  m_tok;
  int  m_r, m_c;
  int  m_elems[$];
  int  m_idx;

  uart_matrix_parser dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .save_done(save_done), .parse_err(parse_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WDW-1:0] obs, input logic [WDW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_acc = 0; m_tok = 0; m_r = 0; m_c = 0; m_idx = 0;
    m_elems.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, output bit w, output bit e,
                            output int widx, output int wrow, output int wcol,
                            output logic [WDW-1:0] wd);
    int tok;
    w = 0; e = 0; widx = 0; wrow = 0; wcol = 0; wd = '0;
    if (m_mode == 3) begin
      if (b == 8'h0A) m_mode = 0;
      return;
    end
    if (b >= "0" && b <= "9") begin
      if (m_acc * 10 + int'(b - 8'h30) > 255) e = 1;
      else begin m_acc = m_acc * 10 + int'(b - 8'h30); m_tok = 1; end
    end else if (b == 8'h20 || b == 8'h0D || b == 8'h0A) begin
      if (m_tok) begin
        tok = m_acc; m_acc = 0; m_tok = 0;
        if (m_mode == 0) begin
          if (tok >= 1 && tok <= 5) begin m_r = tok; m_mode = 1; end else e = 1;
        end else if (m_mode == 1) begin
          if (tok >= 1 && tok <= 5) begin m_c = tok; m_elems.delete(); m_mode = 2; end
          else e = 1;
        end else begin
          if (tok <= 9) begin
            m_elems.push_back(tok);
            if (m_elems.size() == m_r * m_c) begin
              w = 1; widx = m_idx; wrow = m_r; wcol = m_c;
              foreach (m_elems[k]) wd[k*DW +: DW] = DW'(m_elems[k]);
              m_idx = (m_idx + 1) % 8;
              m_mode = 0;
            end
          end else e = 1;
        end
      end
    end else e = 1;
    if (e) begin
      m_acc = 0; m_tok = 0;
      m_mode = (b == 8'h0A) ? 0 : 3;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit w, e;
    int widx, wrow, wcol;
    logic [WDW-1:0] wd;
    bit exp_busy;
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    model_byte(b, w, e, widx, wrow, wcol, wd);
    exp_busy = w || m_mode == 1 || m_mode == 2 || (m_mode == 0 && m_tok);
    @(negedge clk);
    rx_done = 1'b0;
    chk("wr_en", WDW'(wr_en), WDW'(w));
    chk("save_done", WDW'(save_done), WDW'(w));
    chk("parse_err", WDW'(parse_err), WDW'(e));
    chk("busy", WDW'(busy), WDW'(exp_busy));
    if (w) begin
      chk("wr_idx", WDW'(wr_idx), WDW'(widx));
      chk("wr_row", WDW'(wr_row), WDW'(wrow));
      chk("wr_col", WDW'(wr_col), WDW'(wcol));
      chk("wr_data", wr_data, wd);
    end
    @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_wr_en", WDW'(wr_en), '0);
    chk("rst_save_done", WDW'(save_done), '0);
    chk("rst_parse_err", WDW'(parse_err), '0);
    chk("rst_busy", WDW'(busy), '0);
    chk("rst_wr_idx", WDW'(wr_idx), '0);
    chk("rst_wr_row", WDW'(wr_row), '0);
    chk("rst_wr_col", WDW'(wr_col), '0);
    chk("rst_wr_data", wr_data, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic string rand_sep();
    case ($urandom_range(0, 3))
      0: return " ";
      1: return "\r";
      2: return "\n";
      default: return "  ";
    endcase
  endfunction

  initial begin
    string s;
    string junk;
    int r, c;
    rst = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    do_reset();

    send_str("2 2 1 2 3 4\n");
    for (int i = 0; i < 9; i++) send_str("1 1 5 ");
    send_str("6 2 1\n");
    send_str("1 1 7\n");
    send_str("2 1 3 X 4\n");
    send_str("1 1 4\n");
    send_str("1 1 300 \n");
    send_str("1 1 2\n");
    send_str("  1\r\n\n  3 0 1 2\n");
    send_str("5 5 ");
    for (int k = 0; k < 25; k++) send_str($sformatf("%0d ", k % 10));
    send_str("3 2 9 10\n");

    send_str("3 3 1 2 ");
    do_reset();
    send_str("1 1 9 ");

    junk = "0123456789 xA\n";
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(1, 5);
      c = $urandom_range(1, 5);
      s = {$sformatf("%0d", r), rand_sep(), $sformatf("%0d", c), rand_sep()};
      for (int k = 0; k < r * c; k++)
        s = {s, $sformatf("%0d", $urandom_range(0, 9)), rand_sep()};
      if ($urandom_range(0, 3) == 0)
        s.putc($urandom_range(0, s.len() - 1), junk[$urandom_range(0, junk.len() - 1)]);
      s = {s, "\n"};
      send_str(s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
